led_mode_selector: RTL and testbench



---
 rtl/led_mode_selector_if.sv | 25 ++
 rtl/led_mode_selector.sv | 135 +++++++++++++
 tb/tb_led_mode_selector.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/led_mode_selector_if.sv
// Button inputs and decoder-facing outputs of led_mode_selector.
// The master drives the raw buttons; the slave (the selector) drives the decoder outputs.
interface led_mode_selector_if;
  logic       btn_start;
  logic       btn_next;
  logic [1:0] value_out;
  logic       main_program;
  logic       press_ack;

  modport master (
    output btn_start,
    output btn_next,
    input  value_out,
    input  main_program,
    input  press_ack
  );

  modport slave (
    input  btn_start,
    input  btn_next,
    output value_out,
    output main_program,
    output press_ack
  );
endinterface

// File: rtl/led_mode_selector.sv
// Debounced two-button IDLE/RUN controller feeding the RGB LED colour decoder.
// Optional idle timeout in RUN is compiled in when LED_MODE_TIMEOUT_EN is defined.
module led_mode_selector #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int IDLE_TIMEOUT    = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  led_mode_selector_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // Index 0 is the start button, index 1 the next button.
  logic [1:0]    w_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_db;
  logic [1:0]    r_db_d;
  logic [CW-1:0] r_cnt [2];
  logic          w_start_evt;
  logic          w_next_evt;

  state_t        r_state;
  logic [1:0]    r_value;
  logic          r_main;
  logic          r_ack;

  assign w_raw       = {bus.btn_next, bus.btn_start};
  assign w_start_evt = r_db[0] & ~r_db_d[0];
  assign w_next_evt  = r_db[1] & ~r_db_d[1];

  // Synchronise and debounce both buttons; r_db_d marks debounced rising edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_db    <= 2'b00;
      r_db_d  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef LED_MODE_TIMEOUT_EN
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(IDLE_TIMEOUT - 1);
  logic [TW-1:0] r_idle_cnt;
  logic          w_timeout;
  // The edge that would bring the counter to IDLE_TIMEOUT is the edge that leaves RUN.
  assign w_timeout = (r_idle_cnt == TO_LAST);
`endif

  // Mode FSM with registered decoder outputs; start always outranks next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_value <= 2'd0;
      r_main  <= 1'b0;
      r_ack   <= 1'b0;
`ifdef LED_MODE_TIMEOUT_EN
      r_idle_cnt <= '0;
`endif
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_value <= 2'd0;
          if (w_start_evt) begin
            r_state <= ST_RUN;
            r_main  <= 1'b1;
            r_ack   <= 1'b1;
`ifdef LED_MODE_TIMEOUT_EN
            r_idle_cnt <= '0;
`endif
          end else begin
            r_main <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_start_evt) begin
            r_state <= ST_IDLE;
            r_main  <= 1'b0;
            r_value <= 2'd0;
            r_ack   <= 1'b1;
          end else if (w_next_evt) begin
            r_value <= r_value + 2'd1;
            r_ack   <= 1'b1;
`ifdef LED_MODE_TIMEOUT_EN
            r_idle_cnt <= '0;
          end else if (w_timeout) begin
            r_state    <= ST_IDLE;
            r_main     <= 1'b0;
            r_value    <= 2'd0;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
`else
          end else begin
            r_main <= 1'b1;
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_main  <= 1'b0;
          r_value <= 2'd0;
        end
      endcase
    end
  end

  assign bus.value_out    = r_value;
  assign bus.main_program = r_main;
  assign bus.press_ack    = r_ack;

endmodule

// File: tb/tb_led_mode_selector.sv
// Directed bench for led_mode_selector with a press_ack scoreboard.
// Define LED_MODE_TIMEOUT_EN to exercise the idle-timeout build.
module tb_led_mode_selector;
  logic clk;
  logic rst_n;
  int   n_err;
  int   n_chk;
  int   n_ack;
  int   ack_base;
  logic [2:0] exp_q [$];

  led_mode_selector_if bus ();

  led_mode_selector #(
    .DEBOUNCE_CYCLES(4),
    .IDLE_TIMEOUT   (50)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every press_ack must match the oldest pending expected {main_program, value_out}.
  always @(negedge clk) begin
    if (rst_n && bus.press_ack === 1'b1) begin
      logic [2:0] e;
      n_ack++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL unexpected_ack observed=%0h expected=none", {bus.main_program, bus.value_out});
      end else begin
        e = exp_q.pop_front();
        assert ({bus.main_program, bus.value_out} === e) else begin
          n_err++;
          $error("FAIL ack_state observed=%0h expected=%0h", {bus.main_program, bus.value_out}, e);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_next(input logic [1:0] expv);
    exp_q.push_back({1'b1, expv});
    bus.btn_next = 1'b1;
    cycles(8);
    bus.btn_next = 1'b0;
    cycles(8);
  endtask

  task automatic press_start(input logic [2:0] expv);
    exp_q.push_back(expv);
    bus.btn_start = 1'b1;
    cycles(8);
    bus.btn_start = 1'b0;
    cycles(8);
  endtask

  initial begin
    n_err = 0; n_chk = 0; n_ack = 0;
    rst_n = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_next  = 1'b0;
    cycles(3);
    check("reset_value", {6'd0, bus.value_out}, 8'd0);
    check("reset_main", {7'd0, bus.main_program}, 8'd0);
    check("reset_ack", {7'd0, bus.press_ack}, 8'd0);
    rst_n = 1'b1;
    cycles(2);

    // Start latency: outputs change on the 7th edge after the first high sample.
    ack_base = n_ack;
    exp_q.push_back(3'b100);
    bus.btn_start = 1'b1;
    cycles(6);
    check("start_not_early", {7'd0, bus.main_program}, 8'd0);
    cycles(1);
    check("start_main", {7'd0, bus.main_program}, 8'd1);
    check("start_value", {6'd0, bus.value_out}, 8'd0);
    check("start_ack", {7'd0, bus.press_ack}, 8'd1);
    cycles(3);
    bus.btn_start = 1'b0;
    cycles(10);
    check("start_ack_count", 8'(n_ack - ack_base), 8'd1);

    // Five clean next presses step 1,2,3,0,1.
    ack_base = n_ack;
    press_next(2'd1);
    check("next_v1", {6'd0, bus.value_out}, 8'd1);
    press_next(2'd2);
    press_next(2'd3);
    check("next_v3", {6'd0, bus.value_out}, 8'd3);
    press_next(2'd0);
    check("next_wrap", {6'd0, bus.value_out}, 8'd0);
    press_next(2'd1);
    check("next_v1b", {6'd0, bus.value_out}, 8'd1);
    check("next_ack_count", 8'(n_ack - ack_base), 8'd5);

    // Bounce every 2 cycles must be filtered.
    ack_base = n_ack;
    for (int i = 0; i < 10; i++) begin
      bus.btn_next = ~bus.btn_next;
      cycles(2);
    end
    bus.btn_next = 1'b0;
    cycles(10);
    check("bounce_value", {6'd0, bus.value_out}, 8'd1);
    check("bounce_ack_count", 8'(n_ack - ack_base), 8'd0);

    press_next(2'd2);
    check("pre_simul_value", {6'd0, bus.value_out}, 8'd2);

    // Simultaneous start and next: start wins, one ack.
    ack_base = n_ack;
    exp_q.push_back(3'b000);
    bus.btn_start = 1'b1;
    bus.btn_next  = 1'b1;
    cycles(8);
    bus.btn_start = 1'b0;
    bus.btn_next  = 1'b0;
    cycles(8);
    check("simul_main", {7'd0, bus.main_program}, 8'd0);
    check("simul_value", {6'd0, bus.value_out}, 8'd0);
    check("simul_ack_count", 8'(n_ack - ack_base), 8'd1);

    // Next in IDLE is ignored.
    ack_base = n_ack;
    bus.btn_next = 1'b1;
    cycles(8);
    bus.btn_next = 1'b0;
    cycles(8);
    check("idle_next_value", {6'd0, bus.value_out}, 8'd0);
    check("idle_next_ack", 8'(n_ack - ack_base), 8'd0);

    // Enter RUN, one next press, then leave the buttons alone.
    press_start(3'b100);
    exp_q.push_back(3'b101);
    bus.btn_next = 1'b1;
    cycles(7);
    check("last_press_ack", {7'd0, bus.press_ack}, 8'd1);
    cycles(1);
    bus.btn_next = 1'b0;
`ifdef LED_MODE_TIMEOUT_EN
    ack_base = n_ack;
    cycles(48);
    check("timeout_not_early", {7'd0, bus.main_program}, 8'd1);
    cycles(1);
    check("timeout_main", {7'd0, bus.main_program}, 8'd0);
    check("timeout_value", {6'd0, bus.value_out}, 8'd0);
    cycles(5);
    check("timeout_no_ack", 8'(n_ack - ack_base), 8'd0);
    press_start(3'b100);
`else
    cycles(210);
    check("hold_main", {7'd0, bus.main_program}, 8'd1);
    check("hold_value", {6'd0, bus.value_out}, 8'd1);
`endif

    // Reset while the start debounce counter sits at 3 in RUN.
    ack_base = n_ack;
    check("pre_reset_main", {7'd0, bus.main_program}, 8'd1);
    bus.btn_start = 1'b1;
    cycles(5);
    rst_n = 1'b0;
    bus.btn_start = 1'b0;
    #1;
    check("midreset_main", {7'd0, bus.main_program}, 8'd0);
    check("midreset_value", {6'd0, bus.value_out}, 8'd0);
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    check("post_reset_main", {7'd0, bus.main_program}, 8'd0);
    check("post_reset_ack", 8'(n_ack - ack_base), 8'd0);
    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
